// File: rtl/fft_loader_pkg.sv
// ---------------------------------------------------------------------------
// fft_loader_pkg
// Shared types and constants for the FFT sample loader.
//   N_POINTS : frame length in samples (power of two)
//   DIN_W    : FFT input width per component (signed)
//   FFT_LAT  : cycles from the last streamed sample to the done pulse
// Optional build macro used by the loader: FFT_LOADER_SAT_EN.
// ---------------------------------------------------------------------------
package fft_loader_pkg;

  localparam int N_POINTS = 32;
  localparam int DIN_W    = 12;
  localparam int FFT_LAT  = 40;
  localparam int IDX_W    = $clog2(N_POINTS);
  localparam int LAT_W    = $clog2(FFT_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } loader_state_e;

  typedef logic signed [DIN_W-1:0] fft_sample_t;

  // Number of loaded indices in a mask (0..N_POINTS).
  function automatic logic [IDX_W:0] popcount(input logic [N_POINTS-1:0] m);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N_POINTS; i++) begin
      c = c + {{IDX_W{1'b0}}, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/fft_sample_sat.sv
// ---------------------------------------------------------------------------
// fft_sample_sat
// Combinational 16-bit -> DIN_W sample width converter.
//   din  : signed 16-bit component from the bus
//   dout : converted DIN_W-bit component
//   sat  : high when the value had to be clipped (saturating build only)
// Build macro FFT_LOADER_SAT_EN: defined -> saturate to the signed DIN_W range;
// undefined -> keep the low DIN_W bits, sat tied low.
// ---------------------------------------------------------------------------
module fft_sample_sat
  import fft_loader_pkg::*;
(
  input  logic [15:0] din,
  output fft_sample_t dout,
  output logic        sat
);

`ifdef FFT_LOADER_SAT_EN
  localparam logic signed [15:0] SAT_MAX = 16'((2 ** (DIN_W - 1)) - 1);
  localparam logic signed [15:0] SAT_MIN = -SAT_MAX - 16'sd1;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the ifs can leave it unassigned and infer a latch.
  always_comb begin
    dout = din[DIN_W-1:0];
    sat  = 1'b0;
    if ($signed(din) > SAT_MAX) begin
      dout = SAT_MAX[DIN_W-1:0];
      sat  = 1'b1;
    end else if ($signed(din) < SAT_MIN) begin
      dout = SAT_MIN[DIN_W-1:0];
      sat  = 1'b1;
    end
  end
`else
  // Upper bits are intentionally discarded by plain truncation.
  logic unused_hi;
  assign unused_hi = ^din[15:DIN_W];
  assign dout      = din[DIN_W-1:0];
  assign sat       = 1'b0;
`endif

endmodule

// File: rtl/fft_sample_loader.sv
// ---------------------------------------------------------------------------
// fft_sample_loader
// Buffers a 32-sample complex frame written at arbitrary times by the bus and
// streams it into the pipelined FFT as 32 contiguous in_valid cycles, then
// waits FFT_LAT cycles and pulses done.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : single-sample write ([15:0] real, [31:16] imag)
//   start               : 1-cycle request to stream the buffered frame
//   busy                : high in STREAM or WAIT
//   done                : 1-cycle pulse at the end of WAIT
//   err                 : sticky error, cleared by an accepted start
//   loaded_cnt          : distinct indices written since the last frame
//   fft_in_valid, fft_din_r, fft_din_i : FFT input stream
// Build macro FFT_LOADER_SAT_EN selects saturating width conversion; a
// saturating write then also raises err.
// ---------------------------------------------------------------------------
module fft_sample_loader
  import fft_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_addr,
  input  logic [31:0]         wr_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W:0]      loaded_cnt,
  output logic                fft_in_valid,
  output logic [DIN_W-1:0]    fft_din_r,
  output logic [DIN_W-1:0]    fft_din_i
);

  // ---------------- width conversion ----------------
  fft_sample_t conv_r, conv_i;
  logic        sat_r, sat_i;

  fft_sample_sat u_sat_r (.din(wr_data[15:0]),  .dout(conv_r), .sat(sat_r));
  fft_sample_sat u_sat_i (.din(wr_data[31:16]), .dout(conv_i), .sat(sat_i));

  // ---------------- state ----------------
  loader_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [N_POINTS-1:0]   mask_q, mask_d;
  logic [IDX_W:0]        cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  valid_q, valid_d;
  fft_sample_t           din_r_q, din_r_d;
  fft_sample_t           din_i_q, din_i_d;

  fft_sample_t           buf_r_q [N_POINTS];
  fft_sample_t           buf_i_q [N_POINTS];

  logic                  store;
  logic [IDX_W-1:0]      idx_nxt;

  // Writes land in the buffer only while idle; otherwise they are dropped.
  assign store   = wr_en && (state_q == IDLE);
  assign idx_nxt = idx_q + 1'b1;

  // NOTE: the sample buffer has no reset -- its contents are meaningless until
  // the mask says an index was written, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (store) begin
      buf_r_q[wr_addr] <= conv_r;
      buf_i_q[wr_addr] <= conv_i;
    end
  end

  // NOTE: next-state logic uses blocking assignments so later statements see
  // the earlier overrides within the same evaluation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    mask_d  = mask_q;
    err_d   = err_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    din_r_d = din_r_q;
    din_i_d = din_i_q;

    unique case (state_q)
      IDLE: begin
        if (wr_en) mask_d[wr_addr] = 1'b1;
        if (start) begin
          // Judged against the mask as it stood before any same-cycle write.
          if (&mask_q) begin
            state_d = STREAM;
            idx_d   = '0;
            valid_d = 1'b1;
            err_d   = 1'b0;
            // A same-cycle write to index 0 must reach the FFT in this frame.
            if (wr_en && (wr_addr == '0)) begin
              din_r_d = conv_r;
              din_i_d = conv_i;
            end else begin
              din_r_d = buf_r_q[0];
              din_i_d = buf_i_q[0];
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      STREAM: begin
        if (wr_en || start) err_d = 1'b1;
        if (idx_q == IDX_W'(N_POINTS - 1)) begin
          state_d = WAIT;
          lat_d   = '0;
          mask_d  = '0;
        end else begin
          idx_d   = idx_nxt;
          valid_d = 1'b1;
          din_r_d = buf_r_q[idx_nxt];
          din_i_d = buf_i_q[idx_nxt];
        end
      end

      WAIT: begin
        if (wr_en || start) err_d = 1'b1;
        if (lat_q == LAT_W'(FFT_LAT - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A clipped write is flagged even on the edge that accepts start.
    if (wr_en && (sat_r || sat_i)) err_d = 1'b1;

    busy_d = (state_d != IDLE);
    cnt_d  = popcount(mask_d);
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lat_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      din_r_q <= '0;
      din_i_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      din_r_q <= din_r_d;
      din_i_q <= din_i_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign loaded_cnt   = cnt_q;
  assign fft_in_valid = valid_q;
  assign fft_din_r    = din_r_q;
  assign fft_din_i    = din_i_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// ---------------------------------------------------------------------------
// tb_fft_sample_loader
// Self-checking bench for fft_sample_loader. A reference model (sample array +
// loaded set) predicts each streamed frame; expected samples are queued when a
// start is accepted and a monitor compares them against every fft_in_valid
// cycle. Build macro FFT_LOADER_SAT_EN selects the saturating expectations.
// ---------------------------------------------------------------------------
module tb_fft_sample_loader;

  localparam int NP  = 32;
  localparam int LAT = 40;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        busy, done, err, fft_in_valid;
  logic [5:0]  loaded_cnt;
  logic [11:0] fft_din_r, fft_din_i;

  fft_sample_loader dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .err(err),
    .loaded_cnt(loaded_cnt), .fft_in_valid(fft_in_valid),
    .fft_din_r(fft_din_r), .fft_din_i(fft_din_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_r [NP];
  logic [11:0] m_i [NP];
  logic [31:0] m_mask;
  bit          m_err;
  logic [23:0] exp_q [$];

  function automatic logic [11:0] conv(input logic [15:0] x, output bit sat);
    int v;
    v   = int'($signed(x));
    sat = 1'b0;
`ifdef FFT_LOADER_SAT_EN
    if (v > 2047) begin sat = 1'b1; v = 2047; end
    if (v < -2048) begin sat = 1'b1; v = -2048; end
`endif
    return 12'(v);
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [31:0] d);
    bit s1, s2;
    m_r[a]    = conv(d[15:0], s1);
    m_i[a]    = conv(d[31:16], s2);
    m_mask[a] = 1'b1;
    if (s1 || s2) m_err = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (fft_in_valid) begin
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stream_sample", 32'({fft_din_i, fft_din_r}), 32'(e));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_write(a, d);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  // Writes every index except 'skip' in random order; pattern data if !rnd.
  task automatic write_frame(input int skip, input bit rnd);
    int order [NP];
    int j, t;
    for (int i = 0; i < NP; i++) order[i] = i;
    for (int i = NP - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < NP; i++) begin
      if (order[i] != skip) begin
        if (rnd) wr(5'(order[i]), $urandom);
        else     wr(5'(order[i]), {16'(-order[i]), 16'(order[i])});
      end
    end
    check("loaded_cnt_after_writes", 32'(loaded_cnt), 32'($countones(m_mask)));
    check("err_after_writes", 32'(err), 32'(m_err));
  endtask

  // Issues start (optionally with a same-cycle write) and follows the frame.
  // mid_kind: 0 none, 1 write ma/md, 2 start, 3 reset -- applied after
  // sampling at window cycle mid_k.
  task automatic run_start(input bit with_wr, input logic [4:0] a, input logic [31:0] d,
                           input int mid_kind, input int mid_k,
                           input logic [4:0] ma, input logic [31:0] md);
    bit accept;
    bit valid_ok, busy_ok;
    int dcount, dk;
    accept = (m_mask == 32'hFFFF_FFFF);
    start = 1'b1;
    if (with_wr) begin wr_en = 1'b1; wr_addr = a; wr_data = d; end
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    if (accept) m_err = 1'b0; else m_err = 1'b1;
    if (with_wr) m_write(a, d);
    if (!accept) begin
      repeat (3) @(negedge clk);
      check("reject_err", 32'(err), 32'd1);
      check("reject_busy", 32'(busy), 32'd0);
      check("reject_loaded_cnt", 32'(loaded_cnt), 32'($countones(m_mask)));
      return;
    end
    for (int i = 0; i < NP; i++) exp_q.push_back({m_i[i], m_r[i]});
    valid_ok = 1'b1; busy_ok = 1'b1; dcount = 0; dk = -1;
    for (int k = 0; k < LAT + NP + 8; k++) begin
      @(negedge clk);
      if (k == 0) check("start_err", 32'(err), 32'(m_err));
      if (fft_in_valid !== (k < NP)) valid_ok = 1'b0;
      if (busy !== (k < NP + LAT)) busy_ok = 1'b0;
      if (done) begin dcount++; dk = k; end
      wr_en = 1'b0; start = 1'b0;
      if (k == mid_k) begin
        case (mid_kind)
          1: begin wr_en = 1'b1; wr_addr = ma; wr_data = md; m_err = 1'b1; end
          2: begin start = 1'b1; m_err = 1'b1; end
          3: begin
            #2 reset_n = 1'b0;
            #1;
            check("rst_valid", 32'(fft_in_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_loaded_cnt", 32'(loaded_cnt), 32'd0);
            check("rst_din", 32'({fft_din_i, fft_din_r}), 32'd0);
            exp_q.delete();
            m_mask = '0; m_err = 1'b0;
            repeat (3) @(posedge clk);
            #1 reset_n = 1'b1;
            return;
          end
          default: ;
        endcase
      end
    end
    m_mask = '0;
    check("valid_window", 32'(valid_ok), 32'd1);
    check("busy_window", 32'(busy_ok), 32'd1);
    check("done_count", 32'(dcount), 32'd1);
    check("done_cycle", 32'(dk), 32'(NP + LAT));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("end_loaded_cnt", 32'(loaded_cnt), 32'd0);
    check("end_err", 32'(err), 32'(m_err));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    m_mask = '0; m_err = 1'b0;
    for (int i = 0; i < NP; i++) begin m_r[i] = '0; m_i[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_valid", 32'(fft_in_valid), 32'd0);
    check("reset_loaded_cnt", 32'(loaded_cnt), 32'd0);
    check("reset_din", 32'({fft_din_i, fft_din_r}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame: real = idx, imag = -idx.
    write_frame(-1, 1'b0);
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);

    // Missing index 17: rejected, then completed and accepted.
    write_frame(17, 1'b1);
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);
    wr(5'd17, $urandom);
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);

    // Rewrite of index 5 counts once; streamed sample 5 is the second write.
    wr(5'd5, 32'h0003_0007);
    check("rewrite_cnt1", 32'(loaded_cnt), 32'd1);
    wr(5'd5, 32'h0001_0002);
    check("rewrite_cnt2", 32'(loaded_cnt), 32'd1);
    check("model_sample5", 32'({m_i[5], m_r[5]}), 32'h001_002);
    write_frame(5, 1'b1);
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);

    // Write during STREAM cycle 10 to a not-yet-streamed index: dropped, err.
    write_frame(-1, 1'b1);
    run_start(1'b0, 5'd0, 32'd0, 1, 9, 5'd20, 32'h5A5A_A5A5);

    // Start during WAIT: ignored, err.
    write_frame(-1, 1'b1);
    run_start(1'b0, 5'd0, 32'd0, 2, 50, 5'd0, 32'd0);

    // Extreme values on index 3 (saturate or truncate depending on build).
    write_frame(3, 1'b1);
    wr(5'd3, 32'h8000_7FFF);
    check("extreme_err", 32'(err), 32'(m_err));
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);

    // Full mask + same-cycle write to index 0: new data streams first.
    write_frame(-1, 1'b1);
    run_start(1'b1, 5'd0, 32'h0123_0456, 0, -1, 5'd0, 32'd0);

    // Same-cycle 32nd write: start rejected, mask becomes full, then accepted.
    write_frame(9, 1'b1);
    run_start(1'b1, 5'd9, $urandom, 0, -1, 5'd0, 32'd0);
    check("late_fill_cnt", 32'(loaded_cnt), 32'd32);
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);

    // Reset during STREAM cycle 12, then quiet until a fresh frame.
    write_frame(-1, 1'b1);
    run_start(1'b0, 5'd0, 32'd0, 3, 11, 5'd0, 32'd0);
    repeat (50) @(posedge clk);
    #1;
    check("post_rst_loaded_cnt", 32'(loaded_cnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);
    write_frame(-1, 1'b1);
    run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);

    // A few more random frames.
    for (int f = 0; f < 3; f++) begin
      write_frame(-1, 1'b1);
      run_start(1'b0, 5'd0, 32'd0, 0, -1, 5'd0, 32'd0);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
Upstream feeder for the 32-point pipelined radix-2 FFT. It accepts complex samples written one at a time by the RS5 accelerator bus into a 32-entry buffer. On command it streams the full frame into the FFT as 32 back-to-back in_valid cycles, waits a fixed pipeline latency, then reports completion. It isolates the core's irregular write timing from the FFT's contiguous-input requirement.

Parameters:
N_POINTS, 32, frame length in samples; must be a power of two.
DIN_W, 12, FFT input sample width per component (signed).
FFT_LAT, 40, cycles from the last streamed sample until completion is reported.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe for one sample
wr_addr  in  5  sample index 0..31 (natural order)
wr_data  in  32  [15:0] real part, [31:16] imaginary part, signed 16-bit each
start  in  1  request to stream the buffered frame (1-cycle pulse)
busy  out  1  high while in STREAM or WAIT
done  out  1  1-cycle pulse at end of WAIT
err  out  1  sticky error flag; cleared by an accepted start
loaded_cnt  out  6  number of distinct indices written since the last frame (0..32)
fft_in_valid  out  1  drives FFT in_valid
fft_din_r  out  12  drives FFT din_r
fft_din_i  out  12  drives FFT din_i

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, err, fft_in_valid = 0; fft_din_r/i = 0; loaded mask and loaded_cnt = 0; buffer contents don't-care.
- Buffer: 32 x (2 x DIN_W) registers plus a 32-bit loaded mask. loaded_cnt is the popcount of the mask and is registered.
- Write in IDLE: stores the converted sample at wr_addr and sets mask[wr_addr]. Rewriting an already-loaded index overwrites the data; loaded_cnt does not change.
- Write in STREAM/WAIT: data dropped, err set.
- FSM states IDLE, STREAM, WAIT:
  - IDLE->STREAM: start=1 and mask all ones. err is cleared on that edge.
  - start=1 in IDLE with mask not full: err set, stay in IDLE.
  - start outside IDLE: ignored, err set.
  - STREAM: index counter runs 0..31. fft_in_valid=1 for exactly 32 consecutive cycles. Each cycle fft_din_r/i is the registered buffer[idx]. When idx reaches 31, go to WAIT and clear mask/loaded_cnt.
  - WAIT: counter runs 0..FFT_LAT-1. On terminal count, done=1 for one cycle and go to IDLE.
- Latency: start sampled at edge t puts fft_in_valid high for edges t+1..t+32. done is high for the cycle after edge t+32+FFT_LAT.
- Outside STREAM: fft_in_valid=0 and fft_din_r/i hold their last value.
- Simultaneous wr_en and start in IDLE: start is judged against the mask before the write. The write is always applied.
  - With mask already full: the write completes, then the frame streams including the new data.
  - With the write being the 32nd index: start is rejected with err, and the mask becomes full.
- busy = (state != IDLE), registered.
- Reset mid-STREAM: fft_in_valid drops immediately. A partial frame reached the FFT, so the FFT must be reset alongside this block. The system ties both to the same reset_n.
- Width conversion (default): each 16-bit component is truncated to its low DIN_W bits.

Optional Feature:
FFT_LOADER_SAT_EN
- Defined: each 16-bit component saturates to the signed DIN_W range [-2048, 2047]. A saturating write also sets err.
- Undefined: plain truncation to bits [DIN_W-1:0], with no err side effect.

Decomposition:
- fft_loader_pkg: typedef enum logic [1:0] loader_state_e {IDLE, STREAM, WAIT}; localparams N_POINTS, DIN_W, IDX_W = $clog2(N_POINTS); typedef logic signed [DIN_W-1:0] fft_sample_t.
- Sub-module fft_sample_sat: combinational 16->DIN_W converter, instantiated twice (real, imag). Contains the truncate/saturate selection under FFT_LOADER_SAT_EN.

Test Plan:
- Write indices 0..31 with real=idx, imag=-idx, then start -> fft_in_valid high for exactly 32 cycles, din_r = 0,1,..,31 and din_i = 0,-1,..,-31. After FFT_LAT=40 further cycles done pulses once, busy falls, loaded_cnt=0.
- Write 31 indices (skip 17) then start -> err=1, fft_in_valid never asserts, loaded_cnt=31. Write index 17 then start -> frame streams and err clears.
- Write index 5 twice with 0x0003_0007 then 0x0001_0002 -> loaded_cnt increments once. Streamed sample 5 is (2,1).
- wr_en at cycle 10 of STREAM -> err=1, the write is not stored, and the streamed sequence is unchanged.
- Write real=0x7FFF, imag=0x8000 -> with SAT_EN: din (2047,-2048) and err=1; without: din (0xFFF, 0x000).
- Deassert reset_n during STREAM cycle 12 -> fft_in_valid, busy, done, err = 0 immediately and loaded_cnt=0. After release, no output activity until 32 new writes and a start.
